// File: rtl/processor_pkg.sv
// Shared datapath types for the register file: word and address widths
// and the clear-sequencer state encoding.
package processor_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    typedef logic [15:0] word_t;
    typedef logic [3:0]  reg_addr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage : processor_pkg

// File: rtl/reg_file_demux_decoder.sv
// One-hot write-select decoder: turns a register index into per-register
// load enables, all low when the enable is low.
module decoder_4_to_16 #(
    parameter int ADDR_W = 4
) (
    input  logic                   i_en,
    input  logic [ADDR_W-1:0]      i_addr,
    output logic [(2**ADDR_W)-1:0] o_sel
);

    always_comb begin
        o_sel = '0;
        if (i_en) begin
            o_sel[i_addr] = 1'b1;
        end
    end

endmodule : decoder_4_to_16

// File: rtl/reg_file_demux.sv
// 16x16 register file with a demultiplexed write port, two combinational
// read ports and a sequencer that zeroes one register per cycle on request.
module reg_file_demux
    import processor_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              W_en,
    input  logic [ADDR_W-1:0] W_addr,
    input  logic [DATA_W-1:0] W_data,
    input  logic [ADDR_W-1:0] Ra_addr,
    input  logic [ADDR_W-1:0] Rb_addr,
    output logic [DATA_W-1:0] Ra_data,
    output logic [DATA_W-1:0] Rb_data,
    input  logic              Clr_req,
    output logic              Busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    clr_state_t        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;
    logic [DATA_W-1:0] r_regs [DEPTH];

    logic              w_dec_en;
    logic [ADDR_W-1:0] w_dec_addr;
    logic [DATA_W-1:0] w_dec_data;
    logic [DEPTH-1:0]  w_sel;

    // While clearing, the sequencer owns the decoder and the host write is dropped.
    always_comb begin
        w_dec_en   = W_en;
        w_dec_addr = W_addr;
        w_dec_data = W_data;
        if (r_state == CLEAR) begin
            w_dec_en   = 1'b1;
            w_dec_addr = r_cnt;
            w_dec_data = '0;
        end
    end

    decoder_4_to_16 #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .i_en   (w_dec_en),
        .i_addr (w_dec_addr),
        .o_sel  (w_sel)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_sel[i]) begin
                    r_regs[i] <= w_dec_data;
                end
            end
        end
    end

    // Clear sequencer; Busy is registered alongside the state it mirrors.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Clr_req) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_IDX) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Ra_data = r_regs[Ra_addr];
    assign Rb_data = r_regs[Rb_addr];
    assign Busy    = r_busy;

endmodule : reg_file_demux

// File: tb/tb_reg_file_demux.sv
// Directed bench for reg_file_demux: table of write/read vectors plus
// hand-written sequences around the clear engine and asynchronous reset.
module tb_reg_file_demux;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        W_en;
    logic [3:0]  W_addr;
    logic [15:0] W_data;
    logic [3:0]  Ra_addr;
    logic [3:0]  Rb_addr;
    logic [15:0] Ra_data;
    logic [15:0] Rb_data;
    logic        Clr_req;
    logic        Busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [15:0] ea;
        logic [15:0] eb;
    } vec_t;

    vec_t tbl [8];

    reg_file_demux #(
        .DATA_W (16),
        .ADDR_W (4),
        .DEPTH  (16)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .W_en    (W_en),
        .W_addr  (W_addr),
        .W_data  (W_data),
        .Ra_addr (Ra_addr),
        .Rb_addr (Rb_addr),
        .Ra_data (Ra_data),
        .Rb_data (Rb_data),
        .Clr_req (Clr_req),
        .Busy    (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        W_en   = 1'b1;
        W_addr = a;
        W_data = d;
        tick();
        W_en   = 1'b0;
    endtask

    task automatic fill_pattern();
        for (int k = 0; k < 16; k++) begin
            wr(4'(k), 16'h1000 + 16'(k));
        end
    endtask

    initial begin
        logic [15:0] exp_v;
        bit          seen_idle;

        Reset = 1'b0; W_en = 1'b0; W_addr = '0; W_data = '0;
        Ra_addr = '0; Rb_addr = '0; Clr_req = 1'b0;
        #1 Reset = 1'b1;

        // Reset state on both ports for every address
        for (int k = 0; k < 16; k++) begin
            Ra_addr = 4'(k);
            Rb_addr = 4'(15 - k);
            #1;
            chk("reset_ra", Ra_data, 16'h0000);
            chk("reset_rb", Rb_data, 16'h0000);
        end
        chk("reset_busy", {15'b0, Busy}, 16'h0000);
        @(negedge Clk);
        Reset = 1'b0;
        tick();

        // Write/read vectors: reads are checked before the edge (no bypass)
        tbl[0] = '{1'b1, 4'd3,  16'hA5A5, 4'd3,  4'd3,  16'h0000, 16'h0000};
        tbl[1] = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd2,  16'hA5A5, 16'h0000};
        tbl[2] = '{1'b1, 4'd0,  16'hFFFF, 4'd0,  4'd3,  16'h0000, 16'hA5A5};
        tbl[3] = '{1'b1, 4'd15, 16'h8001, 4'd0,  4'd15, 16'hFFFF, 16'h0000};
        tbl[4] = '{1'b0, 4'd15, 16'h7777, 4'd15, 4'd15, 16'h8001, 16'h8001};
        tbl[5] = '{1'b1, 4'd3,  16'h0F0F, 4'd3,  4'd4,  16'hA5A5, 16'h0000};
        tbl[6] = '{1'b0, 4'd3,  16'h1111, 4'd3,  4'd0,  16'h0F0F, 16'hFFFF};
        tbl[7] = '{1'b0, 4'd0,  16'h0000, 4'd4,  4'd14, 16'h0000, 16'h0000};
        for (int i = 0; i < 8; i++) begin
            W_en = tbl[i].we; W_addr = tbl[i].wa; W_data = tbl[i].wd;
            Ra_addr = tbl[i].ra; Rb_addr = tbl[i].rb;
            #1;
            chk($sformatf("vec%0d_ra", i), Ra_data, tbl[i].ea);
            chk($sformatf("vec%0d_rb", i), Rb_data, tbl[i].eb);
            tick();
            W_en = 1'b0;
        end
        for (int k = 0; k < 16; k++) begin
            Ra_addr = 4'(k);
            #1;
            exp_v = (k == 0) ? 16'hFFFF : (k == 3) ? 16'h0F0F : (k == 15) ? 16'h8001 : 16'h0000;
            chk($sformatf("after_tbl_r%0d", k), Ra_data, exp_v);
        end

        // Clear sweep with a dropped write and an ignored second request
        fill_pattern();
        Clr_req = 1'b1;
        tick();
        Clr_req = 1'b0;
        chk("clr_busy_start", {15'b0, Busy}, 16'h0001);
        for (int k = 0; k < 16; k++) begin
            Ra_addr = 4'(k);
            Rb_addr = 4'((k + 1) % 16);
            if (k == 1) begin
                W_en = 1'b1; W_addr = 4'd15; W_data = 16'hBEEF;
            end
            if (k == 4) Clr_req = 1'b1;
            #1;
            chk($sformatf("clr_pre_r%0d", k), Ra_data, 16'h1000 + 16'(k));
            tick();
            W_en = 1'b0;
            Clr_req = 1'b0;
            chk($sformatf("clr_post_r%0d", k), Ra_data, 16'h0000);
            if (k < 15) chk($sformatf("clr_next_r%0d", k + 1), Rb_data, 16'h1000 + 16'(k + 1));
            chk($sformatf("clr_busy_%0d", k), {15'b0, Busy}, (k < 15) ? 16'h0001 : 16'h0000);
        end

        // Same-edge write and clear request: write lands, later zeroed
        W_en = 1'b1; W_addr = 4'd7; W_data = 16'h1234; Clr_req = 1'b1;
        Ra_addr = 4'd7;
        tick();
        W_en = 1'b0; Clr_req = 1'b0;
        for (int t = 0; t < 16; t++) begin
            chk($sformatf("same_edge_t%0d", t), Ra_data, (t < 8) ? 16'h1234 : 16'h0000);
            tick();
        end
        chk("same_edge_busy_end", {15'b0, Busy}, 16'h0000);

        // Clr_req held high: the next clear starts on the first IDLE edge
        Clr_req = 1'b1;
        tick();
        for (int t = 0; t < 16; t++) tick();
        chk("hold_idle_gap", {15'b0, Busy}, 16'h0000);
        tick();
        chk("hold_restart", {15'b0, Busy}, 16'h0001);
        Clr_req = 1'b0;
        seen_idle = 1'b0;
        for (int t = 0; t < 40 && !seen_idle; t++) begin
            tick();
            if (!Busy) seen_idle = 1'b1;
        end
        chk("hold_finish_timeout", {15'b0, seen_idle}, 16'h0001);

        // Asynchronous reset in the middle of a clear
        fill_pattern();
        Clr_req = 1'b1;
        tick();
        Clr_req = 1'b0;
        for (int t = 0; t < 6; t++) tick();
        Ra_addr = 4'd5; Rb_addr = 4'd6;
        #1;
        chk("mid_r5_cleared", Ra_data, 16'h0000);
        chk("mid_r6_kept", Rb_data, 16'h1006);
        chk("mid_busy", {15'b0, Busy}, 16'h0001);
        #1 Reset = 1'b1;
        #1;
        chk("async_busy_drop", {15'b0, Busy}, 16'h0000);
        for (int k = 0; k < 16; k++) begin
            Ra_addr = 4'(k);
            #1;
            chk($sformatf("async_r%0d", k), Ra_data, 16'h0000);
        end
        @(negedge Clk);
        Reset = 1'b0;
        tick();
        wr(4'd0, 16'h1111);
        wr(4'd1, 16'h2222);
        Clr_req = 1'b1;
        tick();
        Clr_req = 1'b0;
        tick();
        Ra_addr = 4'd0; Rb_addr = 4'd1;
        #1;
        chk("restart_r0", Ra_data, 16'h0000);
        chk("restart_r1", Rb_data, 16'h2222);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_reg_file_demux
